// File: rtl/button_bounce_gen.sv
// button_bounce_gen
//   Emulates a mechanical push button: one press produces a bouncy rising
//   edge, a steady hold, and a bouncy falling edge on BTN. Bounce segment
//   lengths come from a free-running 8-bit LFSR, so a given seed and start
//   timing reproduce the same waveform.
//
// Ports
//   clk        single clock, all logic on the rising edge
//   reset      synchronous active-high reset
//   start      request one press (only looked at in IDLE)
//   abort      cancel a press in progress (no done pulse)
//   press_len  hold duration in cycles, latched at accept (0 acts as 1)
//   BTN        registered emulated raw button level
//   busy       high in every state except IDLE
//   done       one-cycle pulse when a press completes
//
// state          | meaning
// ---------------+-----------------------------------------------
// S_IDLE         | BTN low, waiting for start
// S_PRESS_BOUNCE | BTN toggling on each segment expiry, press side
// S_HOLD         | BTN steady high for the latched press length
// S_RELEASE_BOUNCE | BTN toggling on each segment expiry, release side
// S_DONE         | BTN low, done pulse, back to IDLE next cycle

module button_bounce_gen #(
    parameter int          BOUNCE_EDGES = 4,
    parameter int          SEG_BITS     = 3,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [13:0] press_len,
    output logic        BTN,
    output logic        busy,
    output logic        done
);

    localparam int         SW    = SEG_BITS + 1;
    localparam logic [3:0] EDGES = 4'(BOUNCE_EDGES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_BOUNCE,
        S_HOLD,
        S_RELEASE_BOUNCE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [SW-1:0]   seg_q, seg_d;
    logic [3:0]      edge_q, edge_d;
    logic [13:0]     hold_q, hold_d;
    logic [13:0]     plen_q, plen_d;
    logic            btn_q, btn_d;

    logic [SW-1:0]   seg_load;
    logic [13:0]     plen_eff;
    logic            lfsr_fb;

    // Taps for x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    // Segment length is the low LFSR bits plus one, so never zero.
    assign seg_load = SW'(lfsr_q[SEG_BITS-1:0]) + SW'(1);
    assign plen_eff = (press_len == 14'd0) ? 14'd1 : press_len;

    always_comb begin
        state_d = state_q;
        lfsr_d  = {lfsr_q[6:0], lfsr_fb};
        seg_d   = seg_q;
        edge_d  = edge_q;
        hold_d  = hold_q;
        plen_d  = plen_q;
        btn_d   = btn_q;

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            btn_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    btn_d = 1'b0;
                    if (start) begin
                        btn_d  = 1'b1;
                        plen_d = plen_eff;
                        hold_d = plen_eff;
                        edge_d = 4'd0;
                        seg_d  = seg_load;
                        state_d = (BOUNCE_EDGES > 0) ? S_PRESS_BOUNCE : S_HOLD;
                    end
                end
                S_PRESS_BOUNCE: begin
                    if (seg_q <= SW'(1)) begin
                        btn_d  = ~btn_q;
                        edge_d = edge_q + 4'd1;
                        seg_d  = seg_load;
                        if (edge_q + 4'd1 == EDGES) begin
                            // Even edge count lands high; force it anyway.
                            btn_d   = 1'b1;
                            hold_d  = plen_q;
                            state_d = S_HOLD;
                        end
                    end else begin
                        seg_d = seg_q - SW'(1);
                    end
                end
                S_HOLD: begin
                    if (hold_q <= 14'd1) begin
                        btn_d = 1'b0;
                        if (BOUNCE_EDGES > 0) begin
                            edge_d  = 4'd0;
                            seg_d   = seg_load;
                            state_d = S_RELEASE_BOUNCE;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        hold_d = hold_q - 14'd1;
                    end
                end
                S_RELEASE_BOUNCE: begin
                    if (seg_q <= SW'(1)) begin
                        btn_d  = ~btn_q;
                        edge_d = edge_q + 4'd1;
                        seg_d  = seg_load;
                        if (edge_q + 4'd1 == EDGES) begin
                            btn_d   = 1'b0;
                            state_d = S_DONE;
                        end
                    end else begin
                        seg_d = seg_q - SW'(1);
                    end
                end
                S_DONE: begin
                    btn_d   = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    btn_d   = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            seg_q   <= '0;
            edge_q  <= '0;
            hold_q  <= '0;
            plen_q  <= '0;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            seg_q   <= seg_d;
            edge_q  <= edge_d;
            hold_q  <= hold_d;
            plen_q  <= plen_d;
            btn_q   <= btn_d;
        end
    end

    assign BTN  = btn_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_button_bounce_gen.sv
// Testbench for button_bounce_gen: one instance without bounce and one with
// four bounce edges share the same stimulus. Each press pushes an expected
// outcome per instance; a negedge monitor reconstructs each press from the
// outputs and compares when the press ends (busy falls). Bounce segment
// lengths are predicted from a reference LFSR that runs alongside.

module tb_button_bounce_gen;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [13:0] press_len;
    logic        btn0, busy0, done0;
    logic        btn4, busy4, done4;

    always #5 clk = ~clk;

    button_bounce_gen #(.BOUNCE_EDGES(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .press_len(press_len), .BTN(btn0), .busy(busy0), .done(done0)
    );

    button_bounce_gen #(.BOUNCE_EDGES(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .press_len(press_len), .BTN(btn4), .busy(busy4), .done(done4)
    );

    typedef struct {
        int hold;
        int ndone;
        int togp;
        int togr;
    } exp_t;

    exp_t q0[$];
    exp_t q4[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference LFSR: m_prev is the value the DUT used at the latest edge.
    logic [7:0] m_lfsr, m_prev;
    logic       m_rst;
    always @(posedge clk) begin
        m_prev <= m_lfsr;
        m_rst  <= reset;
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    // Monitor state per instance (0: no bounce, 1: four edges)
    int ph[2], run[2], tog_p[2], tog_r[2], hold[2], ndone[2], expseg[2], end_done[2];
    bit btn_p[2], busy_p[2], done_p[2];

    always @(negedge clk) begin : monitor
        int   e;
        logic b, y, d;
        exp_t ex;
        bit   got;
        for (int i = 0; i < 2; i++) begin
            e = (i == 0) ? 0 : 4;
            b = (i == 0) ? btn0  : btn4;
            y = (i == 0) ? busy0 : busy4;
            d = (i == 0) ? done0 : done4;
            if (m_rst) begin
                chk("reset_btn", b, 0);
                chk("reset_busy", y, 0);
                chk("reset_done", d, 0);
            end
            if (!y) chk("done_while_idle", d, 0);
            if (!busy_p[i] && y) begin
                chk("accept_btn_high", b, 1);
                run[i] = 1; tog_p[i] = 0; tog_r[i] = 0;
                hold[i] = -1; ndone[i] = 0; end_done[i] = 0;
                if (e > 0) begin
                    ph[i] = 1;
                    expseg[i] = int'(m_prev[2:0]) + 1;
                end else begin
                    ph[i] = 2;
                end
            end else if (busy_p[i] && !y) begin
                chk("idle_btn_low", b, 0);
                got = 1'b0;
                if (i == 0 && q0.size() > 0) begin ex = q0.pop_front(); got = 1'b1; end
                if (i == 1 && q4.size() > 0) begin ex = q4.pop_front(); got = 1'b1; end
                if (!got) begin
                    total++; bad++;
                    $display("FAIL sb_unexpected_press: dut%0d got a press, expected none", e);
                end else begin
                    chk($sformatf("hold_len_e%0d", e), hold[i], ex.hold);
                    chk($sformatf("done_count_e%0d", e), ndone[i], ex.ndone);
                    if (ex.togp >= 0) chk($sformatf("press_toggles_e%0d", e), tog_p[i], ex.togp);
                    chk($sformatf("release_toggles_e%0d", e), tog_r[i], ex.togr);
                    if (ex.ndone == 1) begin
                        chk("done_last_busy_cycle", int'(done_p[i]), 1);
                        chk("done_right_after_final_edge", end_done[i], 1);
                    end
                end
                ph[i] = 0;
            end else if (y) begin
                if (d) ndone[i]++;
                if (b != btn_p[i]) begin
                    case (ph[i])
                        1: begin
                            chk("seg_press_len", run[i], expseg[i]);
                            tog_p[i]++;
                            run[i] = 1;
                            if (tog_p[i] == e) begin
                                chk("hold_level_high", b, 1);
                                ph[i] = 2;
                            end else begin
                                expseg[i] = int'(m_prev[2:0]) + 1;
                            end
                        end
                        2: begin
                            hold[i] = run[i];
                            run[i] = 1;
                            if (e > 0) begin
                                ph[i] = 3;
                                expseg[i] = int'(m_prev[2:0]) + 1;
                            end else begin
                                ph[i] = 4;
                                end_done[i] = int'(d);
                            end
                        end
                        3: begin
                            chk("seg_release_len", run[i], expseg[i]);
                            tog_r[i]++;
                            run[i] = 1;
                            if (tog_r[i] == e) begin
                                ph[i] = 4;
                                end_done[i] = int'(d);
                            end else begin
                                expseg[i] = int'(m_prev[2:0]) + 1;
                            end
                        end
                        default: tog_r[i]++;
                    endcase
                end else begin
                    run[i]++;
                end
            end
            btn_p[i]  = b;
            busy_p[i] = y;
            done_p[i] = d;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int h, input int nd, input int tp0, input int tr0,
                            input int tp4, input int tr4);
        exp_t a;
        a.hold = h; a.ndone = nd; a.togp = tp0; a.togr = tr0;
        q0.push_back(a);
        a.togp = tp4; a.togr = tr4;
        q4.push_back(a);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy0 || busy4) && n < 3000) begin
            cyc();
            n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL idle_timeout: busy0=%0d busy4=%0d after %0d cycles, expected idle", busy0, busy4, n);
        end
        cyc();
    endtask

    task automatic accept(input int len);
        start = 1'b1;
        press_len = 14'(len);
        cyc();
        start = 1'b0;
    endtask

    task automatic press(input int len, input int hold_exp);
        push_exp(hold_exp, 1, 0, 0, 4, 4);
        accept(len);
        wait_idle();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; press_len = '0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();

        // abort while idle does nothing
        abort = 1'b1; cyc(); abort = 1'b0; cyc();

        press(10, 10);
        press(3, 3);
        press(0, 1);

        // start pulses during the no-bounce HOLD and its DONE cycle
        push_exp(25, 1, 0, 0, 4, 4);
        accept(25);
        repeat (4) cyc();
        start = 1'b1; cyc(); start = 1'b0;
        repeat (20) cyc();
        start = 1'b1; cyc(); start = 1'b0;
        wait_idle();

        // abort while both instances are in HOLD, then a normal press
        push_exp(-1, 0, 0, 0, 4, 0);
        accept(200);
        repeat (99) cyc();
        abort = 1'b1; cyc(); abort = 1'b0;
        wait_idle();
        press(7, 7);

        // reset while the bouncing instance is still in press bounce
        push_exp(-1, 0, 0, 0, -1, 0);
        accept(20);
        cyc();
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        press(10, 10);

        repeat (5) cyc();
        chk("sb_left_e0", q0.size(), 0);
        chk("sb_left_e4", q4.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
